// File: rtl/mem_copy_master.sv
// mem_copy_master
//
// Block copy / fill engine that drives a single-port RAM request port.
// A copy reads one word, waits for its read data, then writes it, one word
// at a time in ascending address order. A fill writes a constant pattern
// once per cycle. Pointers wrap modulo 2^32.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   start_i               begin a transfer (sampled in IDLE only)
//   mode_i                0 = copy, 1 = fill (sampled with start_i)
//   src_addr_i            copy source byte address (bits [1:0] ignored)
//   dst_addr_i            destination byte address (bits [1:0] ignored)
//   len_i                 number of 32-bit words
//   fill_i                fill pattern (sampled with start_i)
//   busy_o                high in every RD / WAIT / WR cycle
//   done_o                one-cycle completion pulse
//   req_o, we_o, be_o,    memory request, write enable, byte enables,
//   addr_o, wdata_o       word-aligned address, write data
//   rvalid_i, rdata_i     read response from the RAM
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start_i
// RD     | read request for the current source word is on the bus
// WAIT   | waiting for rvalid_i of the outstanding read
// WR     | write request for the current destination word is on the bus
// DONE   | done_o pulse, back to IDLE next cycle
//
// All bus outputs are registered: each transition loads the output values
// belonging to the state being entered, so nothing combinational reaches
// an output from an input.

module mem_copy_master #(
    parameter int LenW = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            mode_i,
    input  logic [31:0]     src_addr_i,
    input  logic [31:0]     dst_addr_i,
    input  logic [LenW-1:0] len_i,
    input  logic [31:0]     fill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            req_o,
    output logic            we_o,
    output logic [3:0]      be_o,
    output logic [31:0]     addr_o,
    output logic [31:0]     wdata_o,
    input  logic            rvalid_i,
    input  logic [31:0]     rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_DONE
    } state_t;

    state_t          r_state;
    logic            r_mode;
    logic [31:0]     r_fill;
    logic [31:0]     r_src_ptr;
    logic [31:0]     r_dst_ptr;
    logic [LenW-1:0] r_remaining;
    logic            r_busy;
    logic            r_done;
    logic            r_req;
    logic            r_we;
    logic [3:0]      r_be;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;

    logic [31:0]     w_src_al;
    logic [31:0]     w_dst_al;

    assign w_src_al = src_addr_i & 32'hFFFF_FFFC;
    assign w_dst_al = dst_addr_i & 32'hFFFF_FFFC;

    // r_src_ptr / r_dst_ptr always hold the next address to issue, and
    // r_remaining counts words whose write has not yet been issued. So in
    // WR, r_remaining == 0 means the word on the bus is the last one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_fill      <= '0;
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_be        <= 4'h0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_mode <= mode_i;
                        r_fill <= fill_i;
                        if (len_i == '0) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_src_ptr   <= w_src_al;
                            r_dst_ptr   <= w_dst_al;
                            r_remaining <= '0;
                        end else if (!mode_i) begin
                            r_state     <= S_RD;
                            r_busy      <= 1'b1;
                            r_req       <= 1'b1;
                            r_we        <= 1'b0;
                            r_be        <= 4'h0;
                            r_addr      <= w_src_al;
                            r_src_ptr   <= w_src_al + 32'd4;
                            r_dst_ptr   <= w_dst_al;
                            r_remaining <= len_i;
                        end else begin
                            r_state     <= S_WR;
                            r_busy      <= 1'b1;
                            r_req       <= 1'b1;
                            r_we        <= 1'b1;
                            r_be        <= 4'hF;
                            r_addr      <= w_dst_al;
                            r_wdata     <= fill_i;
                            r_dst_ptr   <= w_dst_al + 32'd4;
                            r_remaining <= len_i - LenW'(1);
                        end
                    end
                end

                S_RD: begin
                    r_state <= S_WAIT;
                    r_req   <= 1'b0;
                end

                S_WAIT: begin
                    if (rvalid_i) begin
                        r_state     <= S_WR;
                        r_req       <= 1'b1;
                        r_we        <= 1'b1;
                        r_be        <= 4'hF;
                        r_addr      <= r_dst_ptr;
                        r_wdata     <= rdata_i;
                        r_dst_ptr   <= r_dst_ptr + 32'd4;
                        r_remaining <= r_remaining - LenW'(1);
                    end
                end

                S_WR: begin
                    if (r_remaining == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_be    <= 4'h0;
                    end else if (!r_mode) begin
                        r_state   <= S_RD;
                        r_req     <= 1'b1;
                        r_we      <= 1'b0;
                        r_be      <= 4'h0;
                        r_addr    <= r_src_ptr;
                        r_src_ptr <= r_src_ptr + 32'd4;
                    end else begin
                        r_addr      <= r_dst_ptr;
                        r_wdata     <= r_fill;
                        r_dst_ptr   <= r_dst_ptr + 32'd4;
                        r_remaining <= r_remaining - LenW'(1);
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_req   <= 1'b0;
                    r_we    <= 1'b0;
                    r_be    <= 4'h0;
                end
            endcase
        end
    end

    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign req_o   = r_req;
    assign we_o    = r_we;
    assign be_o    = r_be;
    assign addr_o  = r_addr;
    assign wdata_o = r_wdata;

endmodule

// File: tb/tb_mem_copy_master.sv
// Testbench for mem_copy_master: a RAM responder with configurable read
// latency plus a transaction-level reference model that predicts every bus
// request (cycle, address, data), the done_o cycle and the busy cycle count.

module tb_mem_copy_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] src = '0;
    logic [31:0] dst = '0;
    logic [15:0] len = '0;
    logic [31:0] fill = '0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        busy_o, done_o, req_o, we_o;
    logic [3:0]  be_o;
    logic [31:0] addr_o, wdata_o;

    always #5 clk = ~clk;

    mem_copy_master #(.LenW(16)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .mode_i     (mode),
        .src_addr_i (src),
        .dst_addr_i (dst),
        .len_i      (len),
        .fill_i     (fill),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .req_o      (req_o),
        .we_o       (we_o),
        .be_o       (be_o),
        .addr_o     (addr_o),
        .wdata_o    (wdata_o),
        .rvalid_i   (rvalid),
        .rdata_i    (rdata)
    );

    typedef struct {
        int          cyc;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } tr_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] ram [256];
    tr_t         act_q[$];
    int          done_q[$];
    int          busy_cnt = 0;
    rsp_t        pend_q[$];
    int          lat = 1;
    bit          spur = 1'b0;

    // RAM responder and bus logger; runs on the falling edge so it samples
    // settled outputs and its rvalid/rdata are stable at the next rising edge.
    task automatic monitor_loop();
        tr_t t;
        rsp_t r;
        forever begin
            @(negedge clk);
            cyc++;
            rvalid = 1'b0;
            rdata  = $urandom();
            if (busy_o) busy_cnt++;
            if (done_o) done_q.push_back(cyc);
            if (req_o) begin
                t.cyc = cyc; t.we = we_o; t.addr = addr_o; t.wdata = wdata_o; t.be = be_o;
                act_q.push_back(t);
                if (we_o) ram[addr_o[9:2]] = wdata_o;
            end
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                rvalid = 1'b1;
                rdata  = pend_q[0].data;
                void'(pend_q.pop_front());
            end else if (spur && req_o && we_o) begin
                rvalid = 1'b1;
                rdata  = 32'hBAD0_BAD0;
            end
            if (req_o && !we_o) begin
                r.due = cyc + lat; r.data = ram[addr_o[9:2]];
                pend_q.push_back(r);
            end
        end
    endtask

    task automatic kick(input bit md, input logic [31:0] s_a, input logic [31:0] d_a,
                        input logic [15:0] n, input logic [31:0] f, output int s);
        @(negedge clk);
        #1;
        mode = md; src = s_a; dst = d_a; len = n; fill = f;
        start = 1'b1;
        act_q.delete(); done_q.delete(); pend_q.delete();
        busy_cnt = 0;
        s = cyc;
    endtask

    // Runs one transfer and checks it against the model. extra_at > 0 pulses
    // a second, conflicting start in that cycle, which must be ignored.
    task automatic run_xfer(input string name, input bit md, input logic [31:0] s_a,
                            input logic [31:0] d_a, input logic [15:0] n,
                            input logic [31:0] f, input int l, input bit sp,
                            input int extra_at);
        logic [31:0] m [256];
        tr_t         exp_q[$];
        tr_t         e;
        logic [31:0] ra, wa, d;
        int          exp_done, s, rel, per, cnt, dg, bad;
        m = ram;
        lat = l; spur = sp; per = 2 + l;
        if (n == 0) begin
            exp_done = 1;
        end else if (!md) begin
            for (int k = 0; k < int'(n); k++) begin
                ra = (s_a & 32'hFFFF_FFFC) + 32'(4 * k);
                wa = (d_a & 32'hFFFF_FFFC) + 32'(4 * k);
                d  = m[ra[9:2]];
                e.cyc = k * per + 1; e.we = 1'b0; e.addr = ra; e.wdata = '0; e.be = 4'h0;
                exp_q.push_back(e);
                e.cyc = k * per + 2 + l; e.we = 1'b1; e.addr = wa; e.wdata = d; e.be = 4'hF;
                exp_q.push_back(e);
                m[wa[9:2]] = d;
            end
            exp_done = int'(n) * per + 1;
        end else begin
            for (int k = 0; k < int'(n); k++) begin
                wa = (d_a & 32'hFFFF_FFFC) + 32'(4 * k);
                e.cyc = k + 1; e.we = 1'b1; e.addr = wa; e.wdata = f; e.be = 4'hF;
                exp_q.push_back(e);
                m[wa[9:2]] = f;
            end
            exp_done = int'(n) + 1;
        end

        kick(md, s_a, d_a, n, f, s);
        rel = 0;
        while (rel < exp_done + 3) begin
            @(negedge clk);
            #1;
            rel = cyc - s;
            if (rel == 1) start = 1'b0;
            if (extra_at > 0 && rel == extra_at) begin
                start = 1'b1; mode = ~md; len = 16'd5; src = 32'h0; dst = 32'h0;
            end
            if (extra_at > 0 && rel == extra_at + 1) start = 1'b0;
        end
        start = 1'b0;
        spur  = 1'b0;

        tests++;
        if (act_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s txn_count: got %0d want %0d", name, act_q.size(), exp_q.size());
        end
        cnt = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < cnt; i++) begin
            tests++;
            if ((act_q[i].cyc - s) != exp_q[i].cyc || act_q[i].we !== exp_q[i].we ||
                act_q[i].addr !== exp_q[i].addr || act_q[i].be !== exp_q[i].be ||
                (exp_q[i].we && act_q[i].wdata !== exp_q[i].wdata)) begin
                fails++;
                $display("FAIL %s txn[%0d]: got cyc=%0d we=%0b addr=%h be=%h wd=%h want cyc=%0d we=%0b addr=%h be=%h wd=%h",
                         name, i, act_q[i].cyc - s, act_q[i].we, act_q[i].addr, act_q[i].be,
                         act_q[i].wdata, exp_q[i].cyc, exp_q[i].we, exp_q[i].addr,
                         exp_q[i].be, exp_q[i].wdata);
            end
        end
        dg = (done_q.size() > 0) ? done_q[0] - s : -1;
        tests++;
        if (done_q.size() != 1 || dg != exp_done) begin
            fails++;
            $display("FAIL %s done: got %0d pulses first at cycle %0d want 1 pulse at cycle %0d",
                     name, done_q.size(), dg, exp_done);
        end
        tests++;
        if (busy_cnt != exp_done - 1) begin
            fails++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, exp_done - 1);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== m[i]) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s ram_contents: got %0d differing words want 0", name, bad);
        end
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: got busy=%b done=%b want 0 0", busy_o, done_o);
        end
        tests++;
        if (req_o !== 1'b0 || we_o !== 1'b0 || be_o !== 4'h0) begin
            fails++;
            $display("FAIL reset_ctrl: got req=%b we=%b be=%h want 0 0 0", req_o, we_o, be_o);
        end
        tests++;
        if (addr_o !== 32'h0 || wdata_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: got addr=%h wdata=%h want 0 0", addr_o, wdata_o);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_copy_basic();
        ram[64] = 32'h1111_1111; ram[65] = 32'h2222_2222;
        ram[66] = 32'h3333_3333; ram[67] = 32'h4444_4444;
        run_xfer("copy4", 1'b0, 32'h100, 32'h200, 16'd4, 32'h0, 1, 1'b0, 0);
    endtask

    task automatic test_fill_basic();
        run_xfer("fill3", 1'b1, 32'h0, 32'h43, 16'd3, 32'hDEAD_BEEF, 1, 1'b0, 0);
    endtask

    task automatic test_len_zero();
        run_xfer("len0_copy", 1'b0, 32'h10, 32'h20, 16'd0, 32'h0, 1, 1'b0, 0);
        run_xfer("len0_fill", 1'b1, 32'h10, 32'h20, 16'd0, 32'h1234_5678, 1, 1'b0, 0);
    endtask

    task automatic test_slow_responder();
        ram[96] = 32'hCAFE_0001; ram[97] = 32'hCAFE_0002;
        run_xfer("slow_copy2", 1'b0, 32'h180, 32'h281, 16'd2, 32'h0, 3, 1'b1, 0);
    endtask

    task automatic test_start_while_busy();
        run_xfer("fill_wrap", 1'b1, 32'h0, 32'hFFFF_FFF8, 16'd3, 32'hA5A5_5A5A, 1, 1'b0, 2);
        run_xfer("start_in_done", 1'b0, 32'h40, 32'h3F0, 16'd2, 32'h0, 1, 1'b0, 7);
    endtask

    task automatic test_reset_mid();
        int s, rel;
        lat = 1; spur = 1'b0;
        kick(1'b0, 32'h100, 32'h300, 16'd5, 32'h0, s);
        rel = 0;
        while (rel < 6) begin
            @(negedge clk);
            #1;
            rel = cyc - s;
            if (rel == 1) start = 1'b0;
        end
        tests++;
        if (req_o !== 1'b1 || we_o !== 1'b1 || addr_o !== 32'h304) begin
            fails++;
            $display("FAIL rst_mid_pre: got req=%b we=%b addr=%h want 1 1 00000304", req_o, we_o, addr_o);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (req_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_drop: got req=%b busy=%b want 0 0", req_o, busy_o);
        end
        tests++;
        if (we_o !== 1'b0 || be_o !== 4'h0 || addr_o !== 32'h0 || wdata_o !== 32'h0 || done_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_outputs: got we=%b be=%h addr=%h wdata=%h done=%b want all 0",
                     we_o, be_o, addr_o, wdata_o, done_o);
        end
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (done_q.size() != 0) begin
            fails++;
            $display("FAIL rst_mid_no_done: got %0d done pulses want 0", done_q.size());
        end
        pend_q.delete();
        rst_n = 1'b1;
        ram[8] = 32'h0BAD_F00D;
        run_xfer("post_rst_copy1", 1'b0, 32'h20, 32'h80, 16'd1, 32'h0, 1, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 256; i++) ram[i] = $urandom();
            run_xfer($sformatf("rand%0d", it), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                     16'($urandom_range(0, 8)), $urandom(), int'($urandom_range(1, 3)),
                     1'($urandom_range(0, 1)), 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        fork
            monitor_loop();
        join_none
        test_reset();
        test_copy_basic();
        test_fill_basic();
        test_len_zero();
        test_slow_responder();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
